// File: rtl/load_sched_pkg.sv
// Shared types and constants for the load instruction scheduler.
// The HALT state exists only when LOAD_SCHED_TIMEOUT_EN is defined.
package load_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
`ifdef LOAD_SCHED_TIMEOUT_EN
    S_HALT  = 2'd3,
`endif
    S_WAIT  = 2'd2
  } state_e;

  localparam int GRP_LSB       = 0;
  localparam int GRP_W         = 6;
  localparam int BUF_START_LSB = 32;
  localparam int BUF_LEN_LSB   = 48;
  localparam int DRAM_ADDR_LSB = 64;
  localparam int BYTE_LEN_LSB  = 80;
  localparam int FIELD_W       = 16;

  localparam logic [GRP_W-1:0] GRP_BUF0  = 6'h01;
  localparam logic [GRP_W-1:0] GRP_BUF1A = 6'h02;
  localparam logic [GRP_W-1:0] GRP_BUF1B = 6'h04;
  localparam logic [GRP_W-1:0] GRP_BUF2A = 6'h08;
  localparam logic [GRP_W-1:0] GRP_BUF2B = 6'h10;

  localparam int BUF_DEPTH = 2048;

  // Widened arithmetic so an overflowing start+len or len*bytes cannot alias to a legal value.
  function automatic logic inst_legal(input logic [GRP_W-1:0] grp,
                                      input logic [FIELD_W-1:0] bs,
                                      input logic [FIELD_W-1:0] bl,
                                      input logic [FIELD_W-1:0] by,
                                      input logic [31:0] dw_bytes);
    logic        grp_ok;
    logic [16:0] end17;
    logic [21:0] need22;
    grp_ok = (grp == GRP_BUF0) || (grp == GRP_BUF1A) || (grp == GRP_BUF1B) ||
             (grp == GRP_BUF2A) || (grp == GRP_BUF2B);
    end17  = {1'b0, bs} + {1'b0, bl};
    need22 = {6'd0, bl} * dw_bytes[21:0];
    return grp_ok && (bl != '0) && (end17 <= 17'(BUF_DEPTH)) && (need22 == {6'd0, by});
  endfunction

endpackage

// File: rtl/load_sched_fifo.sv
// Synchronous instruction queue: flop storage, head read straight from the
// storage array, occupancy carried with one extra bit.
module load_sched_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/load_scheduler.sv
// Queues LOAD instructions, drops illegal ones, issues legal ones to `load`
// via ap_start/ap_done and reports retirements. LOAD_SCHED_TIMEOUT_EN adds a WAIT watchdog.
module load_scheduler
  import load_sched_pkg::*;
#(
  parameter int LOAD_INST_LENGTH   = 128,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int FIFO_DEPTH         = 8,
  parameter int LP_DW_BYTES        = 64,
  parameter int TIMEOUT_CYCLES     = 65536
) (
  input  logic                          kernel_clk,
  input  logic                          kernel_rst_n,
  input  logic                          inst_valid,
  output logic                          inst_ready,
  input  logic [LOAD_INST_LENGTH-1:0]   inst_data,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cfg_addr_offset,
  output logic                          load_ap_start,
  output logic [LOAD_INST_LENGTH-1:0]   load_ctrl_instruction,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] load_ctrl_addr_offset,
  input  logic                          load_ap_done,
  output logic                          retire_valid,
  output logic [5:0]                    retire_group,
  output logic                          err_illegal,
  output logic [15:0]                   err_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
`ifdef LOAD_SCHED_TIMEOUT_EN
  , output logic                        err_timeout
`endif
);
  state_e                          state_q, state_d;
  logic [LOAD_INST_LENGTH-1:0]     inst_q, inst_d, head;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                            rv_q, rv_d, ill_q, ill_d;
  logic [5:0]                      rg_q, rg_d;
  logic [15:0]                     ec_q, ec_d;
  logic                            pop, empty, full, head_legal;
`ifdef LOAD_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;
  assign err_timeout = to_q;
`endif

  load_sched_fifo #(.W(LOAD_INST_LENGTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(kernel_clk), .rst_ni(kernel_rst_n),
    .push_i(inst_valid), .din_i(inst_data), .pop_i(pop),
    .dout_o(head), .full_o(full), .empty_o(empty), .count_o(fifo_count)
  );

  assign head_legal = inst_legal(head[GRP_LSB +: GRP_W], head[BUF_START_LSB +: FIELD_W],
                                 head[BUF_LEN_LSB +: FIELD_W], head[BYTE_LEN_LSB +: FIELD_W],
                                 32'(LP_DW_BYTES));

  always_comb begin
    state_d       = state_q;
    inst_d        = inst_q;
    addr_d        = addr_q;
    rv_d          = 1'b0;
    rg_d          = '0;
    ill_d         = 1'b0;
    ec_d          = ec_q;
    pop           = 1'b0;
    load_ap_start = 1'b0;
`ifdef LOAD_SCHED_TIMEOUT_EN
    wd_d          = wd_q;
    to_d          = to_q;
`endif
    case (state_q)
      S_IDLE: if (!empty) begin
        pop = 1'b1;
        if (head_legal) begin
          inst_d  = head;
          addr_d  = cfg_addr_offset;
          state_d = S_ISSUE;
        end else begin
          ill_d = 1'b1;
          if (ec_q != 16'hFFFF) ec_d = ec_q + 16'd1;
        end
      end
      S_ISSUE: begin
        load_ap_start = 1'b1;
        state_d       = S_WAIT;
`ifdef LOAD_SCHED_TIMEOUT_EN
        wd_d          = '0;
`endif
      end
      S_WAIT: begin
        if (load_ap_done) begin
          rv_d    = 1'b1;
          rg_d    = inst_q[GRP_LSB +: GRP_W];
          state_d = S_IDLE;
`ifdef LOAD_SCHED_TIMEOUT_EN
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          to_d    = 1'b1;
          state_d = S_HALT;
        end else begin
          wd_d = wd_q + WD_W'(1);
`endif
        end
      end
`ifdef LOAD_SCHED_TIMEOUT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge kernel_clk) begin
    if (!kernel_rst_n) begin
      state_q <= S_IDLE;
      inst_q  <= '0;
      addr_q  <= '0;
      rv_q    <= 1'b0;
      rg_q    <= '0;
      ill_q   <= 1'b0;
      ec_q    <= '0;
`ifdef LOAD_SCHED_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
      rv_q    <= rv_d;
      rg_q    <= rg_d;
      ill_q   <= ill_d;
      ec_q    <= ec_d;
`ifdef LOAD_SCHED_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  assign inst_ready            = !full;
  assign load_ctrl_instruction = inst_q;
  assign load_ctrl_addr_offset = addr_q;
  assign retire_valid          = rv_q;
  assign retire_group          = rg_q;
  assign err_illegal           = ill_q;
  assign err_count             = ec_q;
  assign busy                  = (state_q != S_IDLE) || !empty;

endmodule
